// File: rtl/butterfly_pipe.sv
// Pipelined CT/GS NTT butterfly with Barrett reduction and valid/ready handshake.
// Define BFLY_GS_HALVE_EN to scale GS outputs by 2^-1 mod q (q must be odd).
module butterfly_pipe #(
  parameter int W     = 64,
  parameter int TAG_W = 16,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             mode,
  input  logic [W-1:0]     q,
  // floor(2^(2W)/q) exceeds W+2 bits for every q < 2^(W-2), so mu is carried at 2W+1 bits
  input  logic [2*W:0]     mu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_u,
  input  logic [W-1:0]     in_v,
  input  logic [W-1:0]     in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_u,
  output logic [W-1:0]     out_v,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             mode;
    logic [W-1:0]     a;    // u (CT) or (u+v) mod q (GS)
    logic [W-1:0]     m;    // multiplicand: v (CT) or (u-v) mod q (GS)
    logic [W-1:0]     w;
    logic [2*W-1:0]   p;    // m*w
    logic [W-1:0]     t;    // Barrett quotient estimate
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t       st [1:LAT-1];
  stage_t       n1, n2, n3, sl;
  logic [LAT:1] vld_pipe;
  logic         advance;

  logic [W-1:0]     sum_uv, s1_sum, s1_dif;
  logic [4*W:0]     pm;
  logic [2*W-1:0]   tq;
  logic [W-1:0]     r0, r1, vw, ct_sum, ct_u, ct_v, fin_u, fin_v;

`ifdef BFLY_GS_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] x, input logic [W-1:0] qq);
    logic [W-1:0] s;
    s = x[0] ? x + qq : x;
    return s >> 1;
  endfunction
`endif

  assign out_valid = vld_pipe[LAT];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign sl        = st[LAT-1];

  always_comb begin
    // stage 1: GS pre-add/sub so both modes share one multiplier position
    sum_uv  = in_u + in_v;
    s1_sum  = (sum_uv >= q) ? sum_uv - q : sum_uv;
    s1_dif  = (in_u >= in_v) ? in_u - in_v : in_u - in_v + q;
    n1      = '0;
    n1.mode = mode;
    n1.a    = mode ? s1_sum : in_u;
    n1.m    = mode ? s1_dif : in_v;
    n1.w    = in_w;
    n1.tag  = in_tag;
    // stage 2: full product
    n2      = st[1];
    n2.p    = {{W{1'b0}}, st[1].m} * {{W{1'b0}}, st[1].w};
    // stage 3: quotient estimate floor(p*mu / 2^(2W)), at most 2 below the true quotient
    pm      = {{(2*W+1){1'b0}}, st[2].p} * {{(2*W){1'b0}}, mu};
    n3      = st[2];
    n3.t    = pm[3*W-1:2*W];
    // final stage: remainder < 3q fits in W bits, so low-half arithmetic is exact
    tq      = {{W{1'b0}}, sl.t} * {{W{1'b0}}, q};
    r0      = sl.p[W-1:0] - tq[W-1:0];
    r1      = (r0 >= q) ? r0 - q : r0;
    vw      = (r1 >= q) ? r1 - q : r1;
    ct_sum  = sl.a + vw;
    ct_u    = (ct_sum >= q) ? ct_sum - q : ct_sum;
    ct_v    = (sl.a >= vw) ? sl.a - vw : sl.a - vw + q;
    fin_u   = sl.mode ? sl.a : ct_u;
    fin_v   = sl.mode ? vw   : ct_v;
`ifdef BFLY_GS_HALVE_EN
    if (sl.mode) begin
      fin_u = halve(fin_u, q);
      fin_v = halve(fin_v, q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 1; k < LAT; k++) st[k] <= '0;
      out_u    <= '0;
      out_v    <= '0;
      out_tag  <= '0;
    end else begin
      if (advance) begin
        vld_pipe <= {vld_pipe[LAT-1:1], in_valid};
        st[1]    <= n1;
        st[2]    <= n2;
        st[3]    <= n3;
        for (int k = 4; k < LAT; k++) st[k] <= st[k-1];
        out_u    <= fin_u;
        out_v    <= fin_v;
        out_tag  <= sl.tag;
      end
      if (flush) vld_pipe <= '0;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Randomized self-checking bench for butterfly_pipe against a modular-arithmetic model.
module tb_butterfly_pipe;
  localparam int W = 64, TAG_W = 16, LAT = 4;

  logic             clk, rst_n, flush, mode, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     q, in_u, in_v, in_w, out_u, out_v;
  logic [2*W:0]     mu;
  logic [TAG_W-1:0] in_tag, out_tag;

  typedef struct {
    logic [W-1:0]     u;
    logic [W-1:0]     v;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0;

  butterfly_pipe #(.W(W), .TAG_W(TAG_W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode), .q(q), .mu(mu),
    .in_valid(in_valid), .in_ready(in_ready), .in_u(in_u), .in_v(in_v), .in_w(in_w),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u),
    .out_v(out_v), .out_tag(out_tag));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic md, input logic [W-1:0] u, v, w,
                                 input logic [TAG_W-1:0] tg);
    logic [127:0] qq, uu, vv, ww, pr, d, ru, rv;
    exp_t r;
    qq = {64'd0, q}; uu = {64'd0, u}; vv = {64'd0, v}; ww = {64'd0, w};
    if (!md) begin
      pr = (vv * ww) % qq;
      ru = (uu + pr) % qq;
      rv = (uu + qq - pr) % qq;
    end else begin
      ru = (uu + vv) % qq;
      d  = (uu + qq - vv) % qq;
      rv = (d * ww) % qq;
`ifdef BFLY_GS_HALVE_EN
      ru = ru[0] ? (ru + qq) / 2 : ru / 2;
      rv = rv[0] ? (rv + qq) / 2 : rv / 2;
`endif
    end
    r.u = ru[63:0]; r.v = rv[63:0]; r.tag = tg;
    return r;
  endfunction

  // scoreboard: push on accepted input, pop on completed output
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected got tag=%0d with nothing outstanding", out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_u !== e.u || out_v !== e.v || out_tag !== e.tag) begin
            failures++;
            $display("FAIL mon_data got u=%0h v=%0h tag=%0d exp u=%0h v=%0h tag=%0d",
                     out_u, out_v, out_tag, e.u, e.v, e.tag);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(mode, in_u, in_v, in_w, in_tag));
    end
  end

  task automatic set_q(input logic [W-1:0] qv);
    q  = qv;
    mu = (129'd1 << 128) / {65'd0, qv};
  endtask

  task automatic rnd_op(output logic [W-1:0] x);
    x = {$urandom, $urandom} % q;
  endtask

  // present one item at posedge+1, hold until accepted, return at posedge+1 with in_valid=0
  task automatic drive(input logic md, input logic [W-1:0] u, v, w, input logic [TAG_W-1:0] tg);
    bit ok = 0;
    mode = md; in_u = u; in_v = v; in_w = w; in_tag = tg; in_valid = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      failures++;
      $display("FAIL drive_timeout tag=%0d never accepted", tg);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain;
    out_ready = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 0; flush = 0; mode = 0; in_valid = 0; out_ready = 1;
    in_u = 0; in_v = 0; in_w = 0; in_tag = 0;
    set_q(17);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_u !== 0 || out_v !== 0 || out_tag !== 0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b u=%0h v=%0h tag=%0h exp all 0",
               out_valid, out_u, out_v, out_tag);
    end
    checks++;
    if (in_ready !== 1) begin
      failures++; $display("FAIL reset_in_ready got %0b exp 1", in_ready);
    end
    rst_n = 1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0) begin
      failures++; $display("FAIL idle_valid got %0b exp 0", out_valid);
    end
  endtask

  task automatic test_ct_gs;
    logic [W-1:0] eu[2], ev[2];
    eu = '{64'd6, 64'd8};
    ev = '{64'd0, 64'd9};
`ifdef BFLY_GS_HALVE_EN
    eu[1] = 64'd4; ev[1] = 64'd13;
`endif
    set_q(17); out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      int lat = 1;
      drive(i[0], 64'd3, 64'd5, 64'd4, 16'(100 + i));
      while (lat < 50) begin
        @(negedge clk);
        if (out_valid) break;
        lat++;
        @(posedge clk);
      end
      checks++;
      if (lat != LAT) begin
        failures++; $display("FAIL q17_latency mode=%0d got %0d exp %0d", i, lat, LAT);
      end
      checks++;
      if (out_u !== eu[i] || out_v !== ev[i]) begin
        failures++;
        $display("FAIL q17_value mode=%0d got u=%0d v=%0d exp u=%0d v=%0d",
                 i, out_u, out_v, eu[i], ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edge_values;
    logic [W-1:0] qm, op[2], eu[2], ev[2];
    qm = (64'd1 << 61) - 1;
    set_q(qm);
    op = '{qm - 1, 64'd0};
    eu = '{64'd0, 64'd0};
    ev = '{qm - 2, 64'd0};
    for (int i = 0; i < 2; i++) begin
      int lat = 1;
      drive(1'b0, op[i], op[i], op[i], 16'(200 + i));
      while (lat < 50) begin
        @(negedge clk);
        if (out_valid) break;
        lat++;
        @(posedge clk);
      end
      checks++;
      if (out_valid !== 1 || out_u !== eu[i] || out_v !== ev[i]) begin
        failures++;
        $display("FAIL edge_value case=%0d got valid=%0b u=%0h v=%0h exp u=%0h v=%0h",
                 i, out_valid, out_u, out_v, eu[i], ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    set_q(17); out_ready = 1;
    fork
      begin
        logic [W-1:0] u, v, w;
        for (int i = 0; i < 16; i++) begin
          rnd_op(u); rnd_op(v); rnd_op(w);
          drive(i[0], u, v, w, 16'(i));
        end
      end
      begin
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1; break; end
        end
        for (int i = 0; i < 16 && seen; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (out_valid !== 1 || out_tag !== 16'(i)) begin
            failures++;
            $display("FAIL stream_seq idx=%0d got valid=%0b tag=%0d exp valid=1 tag=%0d",
                     i, out_valid, out_tag, i);
          end
        end
        if (!seen) begin
          checks++; failures++; $display("FAIL stream_start got no output exp 16");
        end
      end
    join
    drain();
  endtask

  task automatic test_stall;
    set_q(64'h0000_0FFF_FFFF_FFC5); out_ready = 1;
    fork
      begin
        logic [W-1:0] u, v, w;
        for (int i = 0; i < 14; i++) begin
          rnd_op(u); rnd_op(v); rnd_op(w);
          drive(1'($urandom_range(0, 1)), u, v, w, 16'(300 + i));
        end
      end
      begin
        logic [W-1:0] su, sv;
        logic [TAG_W-1:0] stg;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        su = out_u; sv = out_v; stg = out_tag;
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (out_valid !== 1 || in_ready !== 0) begin
            failures++;
            $display("FAIL stall_handshake cyc=%0d got valid=%0b in_ready=%0b exp 1/0",
                     i, out_valid, in_ready);
          end
          checks++;
          if (out_u !== su || out_v !== sv || out_tag !== stg) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got u=%0h v=%0h tag=%0d exp u=%0h v=%0h tag=%0d",
                     i, out_u, out_v, out_tag, su, sv, stg);
          end
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_flush;
    logic [W-1:0] u, v, w;
    set_q(17); out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_op(u); rnd_op(v); rnd_op(w);
      drive(i[0], u, v, w, 16'(400 + i));
    end
    flush = 1; in_valid = 1; in_tag = 16'hdead;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 0) begin
        failures++;
        $display("FAIL flush_valid cyc=%0d got valid=%0b tag=%0d exp 0", i, out_valid, out_tag);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    logic [W-1:0] u, v, w;
    set_q(17); out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      rnd_op(u); rnd_op(v); rnd_op(w);
      drive(i[0], u, v, w, 16'(500 + i));
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || out_u !== 0 || out_v !== 0 || out_tag !== 0 || in_ready !== 1) begin
      failures++;
      $display("FAIL async_reset got valid=%0b u=%0h v=%0h tag=%0h rdy=%0b exp 0/0/0/0/1",
               out_valid, out_u, out_v, out_tag, in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_op(u); rnd_op(v); rnd_op(w);
      drive(i[0], u, v, w, 16'(600 + i));
    end
    drain();
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      logic [W-1:0] qv;
      bit done = 0;
      qv = ({$urandom, $urandom} >> 2) | 64'd1;
      if (qv < 3) qv = 3;
      set_q(qv);
      fork
        begin
          logic [W-1:0] u, v, w;
          for (int i = 0; i < 60; i++) begin
            rnd_op(u); rnd_op(v); rnd_op(w);
            drive(1'($urandom_range(0, 1)), u, v, w, 16'(1000 + 100 * r + i));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          end
          done = 1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      drain();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ct_gs();
    test_edge_values();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
